// File: rtl/uifdma_pkg.sv
// Shared definitions for the FDMA AXI engines: FSM encoding, AXI constants
// and the burst-length calculation used when a request is split into bursts.
package uifdma_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_CALC = 3'd1,
        ST_AW   = 3'd2,
        ST_W    = 3'd3,
        ST_B    = 3'd4
    } fdma_state_t;

    localparam logic [1:0] BURST_INCR    = 2'b01;
    localparam logic [1:0] RESP_OKAY     = 2'b00;
    localparam logic [3:0] CACHE_DEFAULT = 4'b0011;

    function automatic int clog2(input int unsigned value);
        int          res;
        int unsigned v;
        res = 0;
        v   = value - 32'd1;
        while (v > 32'd0) begin
            res = res + 1;
            v   = v >> 1;
        end
        return res;
    endfunction

    // Beats in the next burst: bounded by what is left, the burst limit and
    // the distance to the next 4 KB page so no burst ever straddles a page.
    function automatic logic [8:0] burst_beats(
        input logic [15:0] rem,
        input logic [11:0] addr_low12,
        input int unsigned bytes,
        input int unsigned max_burst
    );
        int unsigned bnd;
        int unsigned len;
        bnd = (32'd4096 - {20'd0, addr_low12}) / bytes;
        len = {16'd0, rem};
        if (max_burst < len) begin
            len = max_burst;
        end else begin
            len = len;
        end
        if (bnd < len) begin
            len = bnd;
        end else begin
            len = len;
        end
        return len[8:0];
    endfunction

endpackage

// File: rtl/uifdma_axi_wr.sv
// FDMA write engine: turns a line request (address + beat count) into AXI4
// INCR write bursts, one outstanding at a time, never crossing a 4 KB page.
module uifdma_axi_wr
    import uifdma_pkg::*;
#(
    parameter int unsigned AXI_ADDR_WIDTH = 32,
    parameter int unsigned AXI_DATA_WIDTH = 128,
    parameter int unsigned MAX_BURST      = 64,
    parameter int unsigned AXI_ID         = 0
) (
    input  logic                          ui_clk,
    input  logic                          ui_rst,
    input  logic [AXI_ADDR_WIDTH-1:0]     fdma_waddr,
    input  logic                          fdma_wareq,
    input  logic [15:0]                   fdma_wsize,
    output logic                          fdma_wbusy,
    input  logic [AXI_DATA_WIDTH-1:0]     fdma_wdata,
    input  logic                          fdma_wready,
    output logic                          fdma_wvalid,
    output logic                          fdma_wdone,
    output logic                          fdma_werr,
    output logic [3:0]                    m_axi_awid,
    output logic [AXI_ADDR_WIDTH-1:0]     m_axi_awaddr,
    output logic [7:0]                    m_axi_awlen,
    output logic [2:0]                    m_axi_awsize,
    output logic [1:0]                    m_axi_awburst,
    output logic [3:0]                    m_axi_awcache,
    output logic [2:0]                    m_axi_awprot,
    output logic                          m_axi_awvalid,
    input  logic                          m_axi_awready,
    output logic [AXI_DATA_WIDTH-1:0]     m_axi_wdata,
    output logic [AXI_DATA_WIDTH/8-1:0]   m_axi_wstrb,
    output logic                          m_axi_wlast,
    output logic                          m_axi_wvalid,
    input  logic                          m_axi_wready,
    input  logic [1:0]                    m_axi_bresp,
    input  logic                          m_axi_bvalid,
    output logic                          m_axi_bready
);

    localparam int unsigned BYTES     = AXI_DATA_WIDTH / 8;
    localparam int          SIZE_LOG2 = clog2(BYTES);

    fdma_state_t               state_r;
    fdma_state_t               state_nxt_s;
    logic [AXI_ADDR_WIDTH-1:0] addr_r;
    logic [AXI_ADDR_WIDTH-1:0] awaddr_r;
    logic [AXI_ADDR_WIDTH-1:0] step_s;
    logic [15:0]               rem_r;
    logic [8:0]                blen_r;
    logic [8:0]                blen_s;
    logic [7:0]                awlen_r;
    logic [7:0]                beat_r;
    logic                      busy_r;
    logic                      done_r;
    logic                      werr_r;
    logic                      beat_last_s;
    logic                      w_hs_s;
    logic                      last_burst_s;

    assign blen_s       = burst_beats(rem_r, addr_r[11:0], BYTES, MAX_BURST);
    assign step_s       = AXI_ADDR_WIDTH'(blen_r) * AXI_ADDR_WIDTH'(BYTES);
    assign beat_last_s  = (beat_r == awlen_r);
    assign w_hs_s       = (state_r == ST_W) && fdma_wready && m_axi_wready;
    assign last_burst_s = (rem_r == {7'd0, blen_r});

    assign m_axi_awid    = 4'(AXI_ID);
    assign m_axi_awaddr  = awaddr_r;
    assign m_axi_awlen   = awlen_r;
    assign m_axi_awsize  = 3'(SIZE_LOG2);
    assign m_axi_awburst = BURST_INCR;
    assign m_axi_awcache = CACHE_DEFAULT;
    assign m_axi_awprot  = 3'b000;
    assign m_axi_wdata   = fdma_wdata;
    assign m_axi_wstrb   = {BYTES{1'b1}};
    assign fdma_wbusy    = busy_r;
    assign fdma_wdone    = done_r;
    assign fdma_werr     = werr_r;

    // State register
    always_ff @(posedge ui_clk or posedge ui_rst) begin
        if (ui_rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state decode
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (fdma_wareq && (fdma_wsize != 16'd0)) begin
                    state_nxt_s = ST_CALC;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_CALC: state_nxt_s = ST_AW;
            ST_AW: begin
                if (m_axi_awready) begin
                    state_nxt_s = ST_W;
                end else begin
                    state_nxt_s = ST_AW;
                end
            end
            ST_W: begin
                if (w_hs_s && beat_last_s) begin
                    state_nxt_s = ST_B;
                end else begin
                    state_nxt_s = ST_W;
                end
            end
            ST_B: begin
                if (m_axi_bvalid && last_burst_s) begin
                    state_nxt_s = ST_IDLE;
                end else if (m_axi_bvalid) begin
                    state_nxt_s = ST_CALC;
                end else begin
                    state_nxt_s = ST_B;
                end
            end
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // Channel handshake outputs decoded from the current state; wvalid follows
    // FIFO availability only, so it never waits on wready.
    always_comb begin
        m_axi_awvalid = 1'b0;
        m_axi_wvalid  = 1'b0;
        m_axi_wlast   = 1'b0;
        m_axi_bready  = 1'b0;
        fdma_wvalid   = 1'b0;
        case (state_r)
            ST_AW: m_axi_awvalid = 1'b1;
            ST_W: begin
                m_axi_wvalid = fdma_wready;
                m_axi_wlast  = beat_last_s;
                fdma_wvalid  = fdma_wready & m_axi_wready;
            end
            ST_B:    m_axi_bready = 1'b1;
            default: m_axi_awvalid = 1'b0;
        endcase
    end

    // Request bookkeeping: address/remaining count, burst registers, status flags
    always_ff @(posedge ui_clk or posedge ui_rst) begin
        if (ui_rst) begin
            addr_r   <= '0;
            awaddr_r <= '0;
            rem_r    <= 16'd0;
            blen_r   <= 9'd0;
            awlen_r  <= 8'd0;
            beat_r   <= 8'd0;
            busy_r   <= 1'b0;
            done_r   <= 1'b0;
            werr_r   <= 1'b0;
        end else begin
            done_r <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (fdma_wareq && (fdma_wsize != 16'd0)) begin
                        addr_r <= fdma_waddr;
                        rem_r  <= fdma_wsize;
                        busy_r <= 1'b1;
                    end
                end
                ST_CALC: begin
                    blen_r   <= blen_s;
                    awaddr_r <= addr_r;
                    awlen_r  <= 8'(blen_s - 9'd1);
                end
                ST_AW: begin
                    beat_r <= 8'd0;
                end
                ST_W: begin
                    if (w_hs_s) begin
                        beat_r <= beat_r + 8'd1;
                    end
                end
                ST_B: begin
                    if (m_axi_bvalid) begin
                        addr_r <= addr_r + step_s;
                        rem_r  <= rem_r - {7'd0, blen_r};
                        if (m_axi_bresp != RESP_OKAY) begin
                            werr_r <= 1'b1;
                        end
                        if (last_burst_s) begin
                            busy_r <= 1'b0;
                            done_r <= 1'b1;
                        end
                    end
                end
                default: busy_r <= 1'b0;
            endcase
        end
    end

endmodule

// File: doc/uifdma_axi_wr.md
Name: uifdma_axi_wr

Overview:
- FDMA write engine sitting directly downstream of the video-buffer block's FDMA write port.
- Accepts a frame-line request as address plus beat count, pulls beats from the buffer's write FIFO, and issues AXI4 INCR write bursts to the DDR controller/HP port.
- Splits each request into bursts of at most MAX_BURST beats, never crossing a 4 KB boundary, with one burst outstanding at a time.

Parameters:
- AXI_ADDR_WIDTH, 32, AXI address width.
- AXI_DATA_WIDTH, 128, AXI/FDMA data width; must be a power of two, 32..1024. BYTES = AXI_DATA_WIDTH/8.
- MAX_BURST, 64, maximum beats per burst; range 1..256.
- AXI_ID, 0, constant AWID value.

Ports:
- ui_clk  in  1  single clock for all logic.
- ui_rst  in  1  asynchronous active-high reset.
- fdma_waddr  in  AXI_ADDR_WIDTH  byte start address; BYTES-aligned.
- fdma_wareq  in  1  request strobe; sampled only in IDLE.
- fdma_wsize  in  16  request length in beats.
- fdma_wbusy  out  1  high from acceptance until the final B response.
- fdma_wdata  in  AXI_DATA_WIDTH  current FIFO head beat.
- fdma_wready  in  1  head beat is available.
- fdma_wvalid  out  1  beat consumed this cycle (FIFO pop).
- fdma_wdone  out  1  one-cycle pulse when a request completes.
- fdma_werr  out  1  sticky flag, set by any non-OKAY BRESP.
- m_axi_awid  out  4  = AXI_ID.
- m_axi_awaddr  out  AXI_ADDR_WIDTH  burst address.
- m_axi_awlen  out  8  beats-1.
- m_axi_awsize  out  3  = log2(BYTES).
- m_axi_awburst  out  2  = 2'b01 (INCR).
- m_axi_awcache  out  4  = 4'b0011.
- m_axi_awprot  out  3  = 0.
- m_axi_awvalid  out  1
- m_axi_awready  in  1
- m_axi_wdata  out  AXI_DATA_WIDTH  = fdma_wdata.
- m_axi_wstrb  out  BYTES  all ones.
- m_axi_wlast  out  1
- m_axi_wvalid  out  1
- m_axi_wready  in  1
- m_axi_bresp  in  2
- m_axi_bvalid  in  1
- m_axi_bready  out  1

Behaviour:
- Reset (async assert, sync release): state IDLE.
  - awvalid, wvalid, wlast, bready, fdma_wbusy, fdma_wvalid, fdma_wdone and fdma_werr are 0.
  - Address and count registers are 0.
- States: IDLE, CALC, AW, W, B.
- IDLE:
  - If fdma_wareq=1 and fdma_wsize!=0: latch addr and rem=fdma_wsize, set busy, go to CALC.
  - If fdma_wsize=0: the request is ignored (no busy, no done).
  - fdma_wareq while busy is ignored.
- CALC, one cycle:
  - bnd = (4096 - addr[11:0]) / BYTES.
  - blen = min(rem, MAX_BURST, bnd).
  - Register awaddr=addr and awlen=blen-1. Go to AW.
- AW: awvalid=1, held stable until awready. Handshake -> W with beat counter=0.
- W:
  - wvalid = fdma_wready; wdata is combinational from fdma_wdata.
  - fdma_wvalid = fdma_wready & m_axi_wready.
  - wlast = (beat counter == awlen).
  - Each handshake increments the counter.
  - The handshake carrying wlast -> B; wvalid deasserts the following cycle.
  - wvalid must not depend on wready (AXI rule); no bubble is inserted when both stay high.
- B:
  - bready=1.
  - On bvalid: if bresp!=0, set fdma_werr.
  - addr += blen*BYTES, wrapping modulo 2^AXI_ADDR_WIDTH; rem -= blen.
  - rem==0: fdma_wbusy=0 and fdma_wdone=1 in the same registered update, go to IDLE. Otherwise go to CALC.
- Latency:
  - wareq at cycle 0 -> busy at 1, awvalid at 2.
  - Last bvalid at n -> done pulse and busy low at n+1.
  - A new request is accepted from cycle n+1.
- fdma_werr clears only on reset.
- Reset mid-burst:
  - All outputs drop immediately.
  - No AXI recovery is performed; the system resets the interconnect together with this block.
- Width rules:
  - rem is 16 bits; blen is 9 bits (max 256).
  - blen*BYTES is computed at AXI_ADDR_WIDTH.

Decomposition:
- Package uifdma_pkg:
  - state encoding.
  - AXI constants: BURST_INCR, RESP_OKAY, CACHE_DEFAULT.
  - function clog2.
  - function burst_beats(rem, addr_low12, bytes, max_burst), returning the CALC result.
- No sub-module; a single FSM file is natural. A future read engine reuses the package.

Test Plan:
- addr 0x1000_0000, size 64, BYTES=16, always-ready -> one burst: awaddr 0x1000_0000, awlen 63, 64 W beats, wlast on beat 64, one done pulse, werr=0.
- size 100 at 0x1000_0000 -> bursts awlen 63 @0x1000_0000 and awlen 35 @0x1000_0400; fdma_wvalid count = 100.
- addr 0x0000_0F00, size 64 -> 4 KB split: awlen 15 @0x0F00, then awlen 47 @0x1000.
- Random stalls on fdma_wready, m_axi_wready and awready:
  - awaddr/awlen are stable while awvalid is high.
  - Data order equals FIFO order.
  - No pops without wready.
- BRESP=2'b10 on the first of two bursts -> werr=1 and stays 1; the second burst still issues; done pulses.
- Reset asserted in the middle of W -> all outputs 0 within the same cycle. After release, wareq while another wareq is pending starts a fresh request; wareq during busy is ignored (no extra AW).
